byte_packer: RTL and testbench
==============================

BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 Parameter swidth, default 8: byte (serial lane) width in bits.
REQ-002 Parameter pwidth, default 32: output word width in bits; SHALL be an integer multiple of swidth (N = pwidth/swidth, N >= 2).
REQ-003 Parameter FILL, default 8'hFF: pad value for unfilled lanes on flush, swidth bits.
REQ-004 Clock  in  1  single clock; all state updates on rising edge.
REQ-005 Reset  in  1  reset is synchronous and active-high.
REQ-006 DIn  in  swidth  incoming lane, driven by the upstream shift-register SOut.
REQ-007 DInValid  in  1  DIn holds a valid lane this cycle.
REQ-008 DInReady  out  1  packer accepts a lane this cycle.
REQ-009 Flush  in  1  single-cycle request to emit a partial word.
REQ-010 Word  out  pwidth  assembled word.
REQ-011 WordValid  out  1  Word is valid.
REQ-012 WordReady  in  1  downstream consumes Word this cycle.
REQ-013 WordLanes  out  clog2(N)+1  count of real (non-pad) lanes in Word, 1..N.

Function
REQ-014 Lane accept SHALL occur when DInValid && DInReady; word transfer SHALL occur when WordValid && WordReady.
REQ-015 Ordering MSB-first: the first lane accepted after an empty assembly SHALL land in Word[pwidth-1 -: swidth], each next lane in the next lower slot.
REQ-016 Internal state: assembly register (pwidth), lane counter cnt (0..N-1), output register + WordValid, flush-pending flag fp.
REQ-017 On accept with cnt < N-1: write lane into slot cnt, cnt <= cnt+1.
REQ-018 On accept with cnt == N-1: the completed word (including this lane) SHALL load the output register next edge, WordValid <= 1, WordLanes <= N, cnt <= 0; latency from last lane accept to WordValid = 1 cycle.
REQ-019 DInReady SHALL equal !fp && !(cnt == N-1 && WordValid); no combinational path from WordReady to DInReady.
REQ-020 WordValid SHALL clear on transfer unless a new word loads the same edge; Word/WordLanes SHALL hold stable while WordValid && !WordReady.
REQ-021 Flush asserted SHALL set fp (a lane accepted in the same cycle is included first); Flush while fp already set is ignored.
REQ-022 With fp set and cnt > 0 and WordValid == 0: output register loads assembly with slots cnt..N-1 set to FILL, WordLanes <= cnt, cnt <= 0, fp <= 0.
REQ-023 With fp set and cnt == 0 (after including any same-cycle lane): fp SHALL clear with no word emitted.
REQ-024 With fp set and WordValid == 1: flush waits; it SHALL execute on the first cycle with WordValid == 0 (not the transfer cycle itself).
REQ-025 Assembly slots not yet written are don't-care internally but SHALL never appear unpadded on Word.
REQ-026 Control logic SHALL be one FSM: EMPTY (cnt==0, no fp), FILLING (cnt>0), FLUSHWAIT (fp set); transitions per REQ-017..REQ-024.

Reset
REQ-027 Reset SHALL force cnt=0, fp=0, WordValid=0, WordLanes=0, Word=0, DInReady=1 on the next edge, overriding any simultaneous accept, transfer or Flush.
REQ-028 Reset mid-word SHALL discard the partial assembly and any pending output word; no word emitted for discarded lanes.

Verification
REQ-029 Lanes F9,AB,CD,EF with DInValid=1 on 4 cycles, WordReady=1 -> one cycle after 4th accept Word=32'hF9ABCDEF, WordLanes=4, WordValid=1 for 1 cycle.
REQ-030 Lanes 12,34 then Flush -> Word=32'h1234FFFF, WordLanes=2; Flush with cnt==0 -> no word, DInReady returns 1 next cycle.
REQ-031 WordReady=0, feed 8 lanes 01..08 continuously -> Word=32'h01020304 held, DInReady=0 with cnt==3; raise WordReady -> 32'h05060708 follows, no lane lost or duplicated.
REQ-032 Lane 0xAA accepted in the same cycle as Flush with cnt==1 (prior 0x55) -> Word=32'h55AAFFFF, WordLanes=2.
REQ-033 Reset asserted after 2 lanes accepted -> all outputs at reset values; next 4 lanes 11,22,33,44 -> Word=32'h11223344.
REQ-034 Random DInValid/WordReady/Flush, 10k cycles vs. reference queue model -> every lane appears exactly once, in order, pads equal FILL.

Source files
------------

// File: rtl/byte_packer.sv
// Packs swidth-bit lanes MSB-first into pwidth-bit words with a one-deep output
// register; a flush emits any partial word padded with FILL in the unused lanes.
module byte_packer #(
  parameter int                swidth = 8,
  parameter int                pwidth = 32,
  parameter logic [swidth-1:0] FILL   = 8'hFF
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic [swidth-1:0]                 i_din,
  input  logic                              i_din_valid,
  output logic                              o_din_ready,
  input  logic                              i_flush,
  output logic [pwidth-1:0]                 o_word,
  output logic                              o_word_valid,
  input  logic                              i_word_ready,
  output logic [$clog2(pwidth/swidth):0]    o_word_lanes
);

  localparam int N  = pwidth / swidth;
  localparam int CW = $clog2(N);
  localparam int LW = CW + 1;

  localparam logic [1:0] S_EMPTY     = 2'd0;
  localparam logic [1:0] S_FILLING   = 2'd1;
  localparam logic [1:0] S_FLUSHWAIT = 2'd2;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [pwidth-1:0] r_asm;
  logic [pwidth-1:0] r_word;
  logic              r_valid;
  logic [LW-1:0]     r_lanes;

  logic              w_fp;
  logic              w_last;
  logic              w_accept;
  logic              w_transfer;
  logic              w_flush_go;
  logic [pwidth-1:0] w_asm_wr;
  logic [pwidth-1:0] w_padded;
  logic [1:0]        w_state_next;
  logic [CW-1:0]     w_cnt_next;
  logic [pwidth-1:0] w_word_next;
  logic              w_valid_next;
  logic [LW-1:0]     w_lanes_next;
  logic              w_fp_next;

  assign w_fp        = (r_state == S_FLUSHWAIT);
  assign w_last      = (r_cnt == CW'(N - 1));
  // Ready depends only on registered state, never on i_word_ready.
  assign o_din_ready = !w_fp && !(w_last && r_valid);
  assign w_accept    = i_din_valid && o_din_ready;
  assign w_transfer  = r_valid && i_word_ready;
  assign w_flush_go  = w_fp && !r_valid;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi = gi + 1) begin : g_slot
      localparam int HI = pwidth - 1 - gi * swidth;
      assign w_asm_wr[HI -: swidth] = (w_accept && (r_cnt == CW'(gi))) ? i_din : r_asm[HI -: swidth];
      assign w_padded[HI -: swidth] = (r_cnt > CW'(gi)) ? r_asm[HI -: swidth] : FILL;
    end
  endgenerate

  always_comb begin
    w_cnt_next   = r_cnt;
    w_word_next  = r_word;
    w_lanes_next = r_lanes;
    w_valid_next = r_valid && !w_transfer;
    w_fp_next    = w_fp;

    if (w_accept) begin
      if (w_last) begin
        w_word_next  = w_asm_wr;
        w_valid_next = 1'b1;
        w_lanes_next = LW'(N);
        w_cnt_next   = '0;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end

    if (!w_fp && i_flush) begin
      w_fp_next = 1'b1;
    end

    // Pending flush runs only once the output register is already empty.
    if (w_flush_go) begin
      w_fp_next = 1'b0;
      if (r_cnt != '0) begin
        w_word_next  = w_padded;
        w_valid_next = 1'b1;
        w_lanes_next = {1'b0, r_cnt};
        w_cnt_next   = '0;
      end
    end

    if (w_fp_next) begin
      w_state_next = S_FLUSHWAIT;
    end else if (w_cnt_next != '0) begin
      w_state_next = S_FILLING;
    end else begin
      w_state_next = S_EMPTY;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_EMPTY;
      r_cnt   <= '0;
      r_asm   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_lanes <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_asm   <= w_asm_wr;
      r_word  <= w_word_next;
      r_valid <= w_valid_next;
      r_lanes <= w_lanes_next;
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_valid;
  assign o_word_lanes = r_lanes;

endmodule

// File: tb/tb_byte_packer.sv
// Directed and randomized checks of byte_packer with 8-bit lanes into 32-bit words.
module tb_byte_packer;

  logic        clk;
  logic        rst;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        flush;
  logic [31:0] word;
  logic        word_valid;
  logic        word_ready;
  logic [2:0]  word_lanes;

  int total;
  int bad;
  logic [7:0] lane_q[$];

  byte_packer #(.swidth(8), .pwidth(32), .FILL(8'hFF)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_din        (din),
    .i_din_valid  (din_valid),
    .o_din_ready  (din_ready),
    .i_flush      (flush),
    .o_word       (word),
    .o_word_valid (word_valid),
    .i_word_ready (word_ready),
    .o_word_lanes (word_lanes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One scoreboarded cycle: observe handshakes before the edge, then advance.
  task automatic cyc();
    logic [7:0] exp_lane;
    #4;
    if (din_valid && din_ready) lane_q.push_back(din);
    if (word_valid && word_ready) begin
      chk("rnd_lanes_range", 32'((word_lanes >= 3'd1) && (word_lanes <= 3'd4)), 32'd1);
      for (int i = 0; i < 4; i++) begin
        if (i < int'(word_lanes)) begin
          if (lane_q.size() == 0) begin
            chk("rnd_extra_lane", 32'(word[31-8*i -: 8]), 32'hxx);
          end else begin
            exp_lane = lane_q.pop_front();
            chk("rnd_lane", 32'(word[31-8*i -: 8]), 32'(exp_lane));
          end
        end else begin
          chk("rnd_pad", 32'(word[31-8*i -: 8]), 32'hFF);
        end
      end
    end
    tick();
  endtask

  task automatic put(input logic [7:0] b);
    din = b;
    din_valid = 1'b1;
    tick();
  endtask

  initial begin
    int k;
    logic acc;
    logic [7:0] seq8 [8];
    total = 0;
    bad = 0;
    rst = 1'b1;
    din = '0;
    din_valid = 1'b0;
    flush = 1'b0;
    word_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_ready", 32'(din_ready), 32'd1);
    chk("rst_word", word, 32'd0);
    chk("rst_lanes", 32'(word_lanes), 32'd0);
    $display("txn reset checked");

    // Full word
    put(8'hF9); put(8'hAB); put(8'hCD); put(8'hEF);
    din_valid = 1'b0;
    chk("full_valid", 32'(word_valid), 32'd1);
    chk("full_word", word, 32'hF9ABCDEF);
    chk("full_lanes", 32'(word_lanes), 32'd4);
    tick();
    chk("full_valid_clr", 32'(word_valid), 32'd0);
    $display("txn full word %h", 32'hF9ABCDEF);

    // Partial flush
    put(8'h12); put(8'h34);
    din_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ready_lo", 32'(din_ready), 32'd0);
    tick();
    chk("flush_valid", 32'(word_valid), 32'd1);
    chk("flush_word", word, 32'h1234FFFF);
    chk("flush_lanes", 32'(word_lanes), 32'd2);
    tick();
    chk("flush_valid_clr", 32'(word_valid), 32'd0);
    $display("txn partial flush %h", 32'h1234FFFF);

    // Flush with nothing assembled
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("eflush_ready", 32'(din_ready), 32'd1);
    chk("eflush_valid", 32'(word_valid), 32'd0);
    tick();
    chk("eflush_valid2", 32'(word_valid), 32'd0);
    $display("txn empty flush");

    // Backpressure: 8 lanes with WordReady low
    for (int i = 0; i < 8; i++) seq8[i] = 8'(i + 1);
    word_ready = 1'b0;
    k = 0;
    din_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      din = seq8[k];
      acc = din_ready;
      tick();
      if (acc && k < 7) k++;
    end
    chk("bp_accepted", 32'(k), 32'd7);
    chk("bp_word", word, 32'h01020304);
    chk("bp_valid", 32'(word_valid), 32'd1);
    chk("bp_ready", 32'(din_ready), 32'd0);
    word_ready = 1'b1;
    tick();
    chk("bp_drain_valid", 32'(word_valid), 32'd0);
    chk("bp_drain_ready", 32'(din_ready), 32'd1);
    din = seq8[7];
    tick();
    din_valid = 1'b0;
    chk("bp_word2", word, 32'h05060708);
    chk("bp_valid2", 32'(word_valid), 32'd1);
    tick();
    chk("bp_valid2_clr", 32'(word_valid), 32'd0);
    $display("txn backpressure %h %h", 32'h01020304, 32'h05060708);

    // Lane accepted in the flush cycle
    put(8'h55);
    din = 8'hAA;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    din_valid = 1'b0;
    tick();
    chk("sflush_word", word, 32'h55AAFFFF);
    chk("sflush_lanes", 32'(word_lanes), 32'd2);
    chk("sflush_valid", 32'(word_valid), 32'd1);
    tick();
    $display("txn same-cycle flush %h", 32'h55AAFFFF);

    // Reset mid-word
    put(8'hDE); put(8'hAD);
    din_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", 32'(word_valid), 32'd0);
    chk("mrst_ready", 32'(din_ready), 32'd1);
    chk("mrst_word", word, 32'd0);
    chk("mrst_lanes", 32'(word_lanes), 32'd0);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    din_valid = 1'b0;
    chk("mrst_word2", word, 32'h11223344);
    chk("mrst_lanes2", 32'(word_lanes), 32'd4);
    tick();
    $display("txn reset mid-word then %h", 32'h11223344);

    // Randomized traffic against a lane queue
    lane_q.delete();
    for (int c = 0; c < 10000; c++) begin
      din_valid  = ($urandom_range(0, 1) == 1);
      din        = 8'($urandom);
      flush      = ($urandom_range(0, 15) == 0);
      word_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    din_valid  = 1'b0;
    word_ready = 1'b1;
    flush      = 1'b0;
    for (int c = 0; c < 6; c++) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    for (int c = 0; c < 10; c++) cyc();
    chk("rnd_queue_empty", 32'(lane_q.size()), 32'd0);
    $display("txn random traffic done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
